hash_arbiter: RTL and testbench

HASH_ARBITER -- requirements
Module: hash_arbiter

---
 rtl/hash_arbiter_if.sv | 32 +++
 rtl/hash_arbiter.sv | 133 +++++++++++++
 tb/tb_hash_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_arbiter_if.sv
// hash_arbiter_if: client-side job streams and core-side strobes of the two-client hash arbiter.
interface hash_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [1:0]  done;
    logic        err;
    logic        core_rst_n;
    logic        core_input;
    logic [7:0]  core_msg;
    logic        core_start;
    logic        core_out;
    logic        core_ready;
    logic [7:0]  core_digest;

    modport slave (
        input  req, in_valid, in_data, out_ready, core_ready, core_digest,
        output gnt, in_ready, out_valid, out_data, done, err,
               core_rst_n, core_input, core_msg, core_start, core_out
    );

    modport master (
        output req, in_valid, in_data, out_ready, core_ready, core_digest,
        input  gnt, in_ready, out_valid, out_data, done, err,
               core_rst_n, core_input, core_msg, core_start, core_out
    );
endinterface

// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin sharing of one byte-serial hash core between two clients,
// one job (message load, hash, digest readout) at a time.
module hash_arbiter #(
    parameter int MSG_BYTES = 64,
    parameter int DIG_BYTES = 32,
    parameter int TIMEOUT   = 4096
) (
    input logic           clk,
    input logic           rst,
    hash_arbiter_if.slave bus
);
    localparam int BW = $clog2(MSG_BYTES + 1);
    localparam int DW = $clog2(DIG_BYTES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_B = BW'(MSG_BYTES - 1);
    localparam logic [DW-1:0] LAST_D = DW'(DIG_BYTES - 1);
    localparam logic [WW-1:0] LAST_W = WW'(TIMEOUT - 1);

    typedef enum logic [3:0] {IDLE, CLEAR, LOAD, START, WAIT, RDREQ, RDCAP, HOLD, DONE} state_t;

    state_t        r_state;
    logic [1:0]    r_gnt, r_in_ready, r_done;
    logic          r_out_valid, r_err, r_core_rst_n, r_core_start, r_core_out, r_rr_next;
    logic [7:0]    r_out_data;
    logic [BW-1:0] r_bytes;
    logic [DW-1:0] r_digs;
    logic [WW-1:0] r_wait;
    logic          w_win, w_xfer;

    // r_rr_next is the client that wins when both request
    assign w_win  = (bus.req == 2'b11) ? r_rr_next : bus.req[1];
    assign w_xfer = |(bus.in_valid & r_in_ready);

    assign bus.gnt        = r_gnt;
    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.core_rst_n = r_core_rst_n;
    assign bus.core_start = r_core_start;
    assign bus.core_out   = r_core_out;
    assign bus.core_input = w_xfer;
    assign bus.core_msg   = w_xfer ? (r_gnt[1] ? bus.in_data[15:8] : bus.in_data[7:0]) : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_in_ready   <= '0;
            r_done       <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_core_start <= 1'b0;
            r_core_out   <= 1'b0;
            r_rr_next    <= 1'b0;
            r_bytes      <= '0;
            r_digs       <= '0;
            r_wait       <= '0;
        end else begin
            r_core_rst_n <= 1'b1;
            r_core_start <= 1'b0;
            r_core_out   <= 1'b0;
            r_done       <= '0;
            r_err        <= 1'b0;
            case (r_state)
                IDLE: if (|bus.req) begin
                    r_gnt        <= w_win ? 2'b10 : 2'b01;
                    r_core_rst_n <= 1'b0;
                    r_bytes      <= '0;
                    r_digs       <= '0;
                    r_wait       <= '0;
                    r_state      <= CLEAR;
                end
                CLEAR: begin
                    r_in_ready <= r_gnt;
                    r_state    <= LOAD;
                end
                // a completing transfer wins over a simultaneous request drop
                LOAD: if (w_xfer && r_bytes == LAST_B) begin
                    r_bytes      <= r_bytes + 1'b1;
                    r_in_ready   <= '0;
                    r_core_start <= 1'b1;
                    r_state      <= START;
                end else if (!(|(bus.req & r_gnt))) begin
                    r_in_ready <= '0;
                    r_done     <= r_gnt;
                    r_err      <= 1'b1;
                    r_state    <= DONE;
                end else if (w_xfer) begin
                    r_bytes <= r_bytes + 1'b1;
                end
                START: r_state <= WAIT;
                WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (bus.core_ready) begin
                        r_core_out <= 1'b1;
                        r_state    <= RDREQ;
                    end else if (r_wait == LAST_W) begin
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                RDREQ: r_state <= RDCAP;
                RDCAP: begin
                    r_out_data  <= bus.core_digest;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_digs      <= r_digs + 1'b1;
                    if (r_digs == LAST_D) begin
                        r_done  <= r_gnt;
                        r_state <= DONE;
                    end else begin
                        r_core_out <= 1'b1;
                        r_state    <= RDREQ;
                    end
                end
                DONE: begin
                    r_rr_next <= ~r_gnt[1];
                    r_gnt     <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: table of whole jobs against a behavioural hash core, plus
// hand-written reset sequences.
module tb_hash_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    hash_arbiter_if bus();

    hash_arbiter #(.MSG_BYTES(64), .DIG_BYTES(32), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] seed;
        int         abort_at;
        bit         stall;
        int         bp;
        bit         gaps;
        logic [1:0] exp_gnt;
        logic       exp_err;
        int         exp_in;
        int         exp_start;
        int         exp_out;
    } vec_t;

    function automatic logic [7:0] dig_fn(input logic [7:0] m [64], input int i);
        logic [7:0] a, b;
        a = m[(2 * i) % 64];
        b = m[(2 * i + 1) % 64];
        return a ^ {b[3:0], b[7:4]} ^ 8'(i * 37 + 5);
    endfunction

    // behavioural core: absorbs bytes, becomes ready a few cycles after start
    logic [7:0] core_mem [64];
    int         c_in = 0, c_rd = 0, c_busy = 0;
    bit         c_started = 0;
    bit         stall_ready = 0;

    always @(posedge clk) begin
        if (!bus.core_rst_n) begin
            c_in <= 0;
            c_rd <= 0;
            c_busy <= 0;
            c_started <= 0;
            bus.core_digest <= 8'h00;
        end else begin
            if (bus.core_input && c_in < 64) begin
                core_mem[c_in] <= bus.core_msg;
                c_in <= c_in + 1;
            end
            if (bus.core_start) begin
                c_started <= 1;
                c_busy <= 3;
            end else if (c_busy > 0) c_busy <= c_busy - 1;
            if (bus.core_out) begin
                bus.core_digest <= dig_fn(core_mem, c_rd);
                c_rd <= c_rd + 1;
            end
        end
    end
    assign bus.core_ready = c_started && c_busy == 0 && !stall_ready;

    int         n_rl = 0, n_in = 0, n_start = 0, n_out = 0;
    logic [7:0] in_log [4096];

    always @(posedge clk) begin
        if (!rst) begin
            if (!bus.core_rst_n) n_rl <= n_rl + 1;
            if (bus.core_start) n_start <= n_start + 1;
            if (bus.core_out) n_out <= n_out + 1;
            if (bus.core_input) begin
                in_log[n_in % 4096] <= bus.core_msg;
                n_in <= n_in + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_msg(input int g, input logic [7:0] msg [64], input int abort_at,
                            input bit gaps, output bit ok);
        int k = 0;
        logic [1:0]  iv;
        logic [15:0] d;
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            if (abort_at > 0 && k == abort_at) begin
                bus.req[g] = 1'b0;
                bus.in_valid = '0;
                ok = 1;
                break;
            end
            if (k == 64) begin
                ok = 1;
                break;
            end
            iv = 2'b11;
            if (gaps && c % 3 == 1) iv[g] = 1'b0;
            d = 16'hEEEE;
            d[8*g +: 8] = msg[k];
            bus.in_valid = iv;
            bus.in_data = d;
            if (iv[g] && bus.in_ready[g]) k++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int s_rl, s_in, s_start, s_out, s_stall_out, g, t_start, t_done, dix, stall_n;
        int stall_bad, gnt_bad, bad_in, bad_dig, got_in;
        logic [7:0] msg [64];
        logic [7:0] got [32];
        logic [7:0] held;
        logic [1:0] g_vec, d_seen;
        logic       e_seen;
        bit         ok;
        for (int i = 0; i < 64; i++) msg[i] = v.seed + 8'(i);
        s_rl = n_rl; s_in = n_in; s_start = n_start; s_out = n_out; s_stall_out = n_out;
        stall_ready = v.stall;
        bus.req = v.req;
        bus.out_ready = 1'b1;
        g_vec = '0;
        for (int c = 0; c < 20 && g_vec == 0; c++) begin
            @(negedge clk);
            g_vec = bus.gnt;
        end
        check("gnt", 64'(g_vec), 64'(v.exp_gnt));
        if (g_vec == 0) return;
        g = g_vec[1] ? 1 : 0;
        load_msg(g, msg, v.abort_at, v.gaps, ok);
        check("load_budget", 64'(ok), 64'd1);
        bus.in_valid = '0;
        t_start = -1; t_done = -1; dix = 0; stall_n = 0; stall_bad = 0; gnt_bad = 0;
        d_seen = '0; e_seen = 1'b0; held = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.gnt != g_vec) gnt_bad++;
            if (bus.core_start) t_start = cyc;
            if (bus.done != 0) begin
                d_seen = bus.done;
                e_seen = bus.err;
                t_done = cyc;
                break;
            end
            if (bus.out_valid && dix == v.bp && stall_n < 5) begin
                if (stall_n == 0) begin
                    held = bus.out_data;
                    s_stall_out = n_out;
                end else if (bus.out_data != held) stall_bad++;
                stall_n++;
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = 1'b1;
                if (bus.out_valid && dix == v.bp)
                    check("bp_no_core_out", 64'(n_out - s_stall_out), 64'd0);
                if (bus.out_valid && dix < 32) begin
                    got[dix] = bus.out_data;
                    dix++;
                end
            end
            @(negedge clk);
        end
        check("done_seen", 64'(t_done >= 0), 64'd1);
        check("done", 64'(d_seen), 64'(v.exp_gnt));
        check("err", 64'(e_seen), 64'(v.exp_err));
        check("gnt_stable", 64'(gnt_bad), 64'd0);
        check("rst_n_low_cycles", 64'(n_rl - s_rl), 64'd1);
        check("n_core_input", 64'(n_in - s_in), 64'(v.exp_in));
        check("n_core_start", 64'(n_start - s_start), 64'(v.exp_start));
        check("n_core_out", 64'(n_out - s_out), 64'(v.exp_out));
        check("n_digest", 64'(dix), 64'(v.exp_out));
        bad_in = 0;
        got_in = n_in - s_in;
        for (int i = 0; i < got_in && i < 64; i++)
            if (in_log[(s_in + i) % 4096] != msg[i]) bad_in++;
        check("in_bytes", 64'(bad_in), 64'd0);
        bad_dig = 0;
        for (int i = 0; i < dix; i++)
            if (got[i] != dig_fn(msg, i)) bad_dig++;
        check("digest_bytes", 64'(bad_dig), 64'd0);
        if (v.bp >= 0) begin
            check("bp_stall_len", 64'(stall_n), 64'd5);
            check("bp_stable", 64'(stall_bad), 64'd0);
        end
        if (v.stall) check("timeout_latency", 64'(t_done - t_start), 64'd17);
        @(negedge clk);
        check("done_pulse_width", 64'(bus.done), 64'd0);
        check("gnt_idle", 64'(bus.gnt), 64'd0);
    endtask

    vec_t tbl [10];
    vec_t post;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         ok;
        int         bad, s_out;
        logic [7:0] m [64];
        tbl[0] = '{2'b11, 8'h00, 0,  0, -1, 0, 2'b01, 1'b0, 64, 1, 32};
        tbl[1] = '{2'b11, 8'h40, 0,  0, -1, 0, 2'b10, 1'b0, 64, 1, 32};
        tbl[2] = '{2'b11, 8'h80, 0,  0, -1, 0, 2'b01, 1'b0, 64, 1, 32};
        tbl[3] = '{2'b01, 8'h00, 0,  0, -1, 0, 2'b01, 1'b0, 64, 1, 32};
        tbl[4] = '{2'b01, 8'h11, 0,  0,  7, 0, 2'b01, 1'b0, 64, 1, 32};
        tbl[5] = '{2'b01, 8'h22, 10, 0, -1, 0, 2'b01, 1'b1, 10, 0, 0};
        tbl[6] = '{2'b10, 8'h33, 0,  0, -1, 0, 2'b10, 1'b0, 64, 1, 32};
        tbl[7] = '{2'b01, 8'h44, 0,  1, -1, 0, 2'b01, 1'b1, 64, 1, 0};
        tbl[8] = '{2'b10, 8'h55, 0,  0, -1, 1, 2'b10, 1'b0, 64, 1, 32};
        tbl[9] = '{2'b11, 8'h66, 0,  0, -1, 0, 2'b01, 1'b0, 64, 1, 32};
        post   = '{2'b11, 8'h77, 0,  0, -1, 0, 2'b01, 1'b0, 64, 1, 32};
        bus.req = '0;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_stream", 64'({bus.in_ready, bus.out_valid, bus.out_data, bus.done, bus.err}), 64'd0);
        check("rst_core", 64'({bus.core_rst_n, bus.core_input, bus.core_msg, bus.core_start, bus.core_out}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("core_rst_n_rise", 64'(bus.core_rst_n), 64'd1);

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // reset while a digest byte is held
        stall_ready = 0;
        bus.out_ready = 1'b0;
        bus.req = 2'b10;
        for (int i = 0; i < 64; i++) m[i] = 8'hA0 ^ 8'(i);
        for (int c = 0; c < 20 && bus.gnt == 0; c++) @(negedge clk);
        load_msg(1, m, 0, 0, ok);
        bus.in_valid = '0;
        for (int c = 0; c < 100 && !bus.out_valid; c++) @(negedge clk);
        check("hold_reached", 64'(bus.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_stream", 64'({bus.gnt, bus.in_ready, bus.out_valid, bus.out_data, bus.done, bus.err}), 64'd0);
        check("async_rst_core", 64'({bus.core_rst_n, bus.core_start, bus.core_out, bus.core_input}), 64'd0);
        bus.req = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s_out = n_out;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.done != 0 || bus.gnt != 0) bad++;
        end
        check("post_rst_idle", 64'(bad), 64'd0);
        check("post_rst_no_core_out", 64'(n_out - s_out), 64'd0);
        run_vec(post);
        bus.req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
